// File: rtl/irq_source_arbiter.sv
// irq_source_arbiter: edge/level capture, masked lowest-index select and req/ack/ret handshake; IRQ_SYNC_EN adds 2-flop input synchronizers
module irq_source_arbiter #(
  parameter int N_SRC = 16,
  parameter logic [N_SRC-1:0] EDGE_MASK = N_SRC'(16'hFFFF),
  parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_SRC-1:0]         irq_src_i,
  input  logic [N_SRC-1:0]         irq_en_i,
  input  logic                     irq_ack_i,
  input  logic                     irq_ret_i,
  output logic                     irq_req_o,
  output logic [31:0]              irq_cause_o,
  output logic [$clog2(N_SRC)-1:0] irq_id_o,
  output logic [N_SRC-1:0]         pending_o
);
  localparam int ID_W = $clog2(N_SRC);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d, src_prev_q, src_s, ready;
  logic [ID_W-1:0] id_q, id_d, sel;
  logic req_q, take;
`ifdef IRQ_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src_i;
      sync2_q <= sync1_q;
    end
  end
  assign src_s = sync2_q;
`else
  assign src_s = irq_src_i;
`endif
  assign ready = pending_q & irq_en_i;
  assign take = (state_q == REQ) && irq_ack_i;
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) sel = ready[i] ? ID_W'(i) : sel;
  end
  // an edge arriving in the ack cycle re-sets the bit being cleared
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < N_SRC; i++)
      pending_d[i] = EDGE_MASK[i] ? ((src_s[i] & ~src_prev_q[i]) | (pending_q[i] & ~(take && id_q == ID_W'(i)))) : src_s[i];
  end
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    case (state_q)
      IDLE: begin
        state_d = |ready ? REQ : IDLE;
        id_d = |ready ? sel : id_q;
      end
      REQ:     state_d = irq_ack_i ? SERVICE : REQ;
      SERVICE: state_d = irq_ret_i ? IDLE : SERVICE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pending_q <= '0;
      src_prev_q <= '0;
      id_q <= '0;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      src_prev_q <= src_s;
      id_q <= id_d;
      req_q <= state_d == REQ;
    end
  end
  assign irq_req_o = req_q;
  assign irq_id_o = id_q;
  assign irq_cause_o = CAUSE_BASE + 32'(id_q);
  assign pending_o = pending_q;
endmodule

// File: tb/tb_irq_source_arbiter.sv
// tb_irq_source_arbiter: directed and random stimulus scored against a behavioural model via an expectation queue
module tb_irq_source_arbiter;
  localparam int N = 16;
  localparam logic [N-1:0] EM = 16'hFFFE;
  localparam logic [31:0] CB = 32'h8000_0010;
  localparam logic [N-1:0] FF = '1;
`ifdef IRQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  logic clk = 0, rst = 1;
  logic [N-1:0] src = '0, en = '0;
  logic ack = 0, ret = 0;
  logic req;
  logic [31:0] cause;
  logic [3:0] id;
  logic [N-1:0] pend;
  int vectors = 0, miscompares = 0;
  typedef struct {bit req; int id; bit [N-1:0] pend;} exp_t;
  exp_t q[$];
  bit [N-1:0] m_pend, m_prev, m_s1, m_s2;
  int m_phase, m_id;

  irq_source_arbiter #(.N_SRC(N), .EDGE_MASK(EM), .CAUSE_BASE(CB)) dut (
    .clk_i(clk), .rst_i(rst), .irq_src_i(src), .irq_en_i(en), .irq_ack_i(ack), .irq_ret_i(ret),
    .irq_req_o(req), .irq_cause_o(cause), .irq_id_o(id), .pending_o(pend));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // phase 0 = waiting, 1 = request outstanding, 2 = in handler
  function automatic void model(bit r, bit [N-1:0] s_in, bit [N-1:0] e, bit a, bit rt);
    bit [N-1:0] s, np;
    int k;
    if (r) begin
      m_pend = '0; m_prev = '0; m_s1 = '0; m_s2 = '0; m_phase = 0; m_id = 0;
      return;
    end
    s = (SL > 0) ? m_s2 : s_in;
    m_s2 = m_s1;
    m_s1 = s_in;
    for (int i = 0; i < N; i++)
      if (!EM[i]) np[i] = s[i];
      else np[i] = (s[i] && !m_prev[i]) || (m_pend[i] && !(m_phase == 1 && a && m_id == i));
    if (m_phase == 0) begin
      k = 0;
      while (k < N && !(m_pend[k] && e[k])) k++;
      if (k < N) begin m_id = k; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (a) m_phase = 2;
    end else if (rt) m_phase = 0;
    m_prev = s;
    m_pend = np;
  endfunction

  task automatic step(bit [N-1:0] s, bit [N-1:0] e, bit a, bit rt, bit r = 0);
    exp_t x;
    rst = r; src = s; en = e; ack = a; ret = rt;
    model(r, s, e, a, rt);
    x.req = (m_phase == 1); x.id = m_id; x.pend = m_pend;
    q.push_back(x);
    if (r) begin
      #1;
      chk("async_rst_req", req, 0);
      chk("async_rst_pend", pend, 0);
    end
    @(negedge clk);
  endtask

  task automatic idle(int n, bit [N-1:0] e = '1);
    repeat (n) step('0, e, 0, 0);
  endtask

  initial forever begin
    exp_t x;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("sb_req", req, x.req);
      chk("sb_id", id, 64'(x.id[3:0]));
      chk("sb_cause", cause, CB + x.id);
      chk("sb_pend", pend, x.pend);
    end
  end

  initial begin
    bit r;
    bit [N-1:0] e;
    @(negedge clk);
    repeat (3) step(N'($urandom), FF, 1, 1, 1);
    chk("rst_req", req, 0); chk("rst_id", id, 0); chk("rst_cause", cause, 32'h8000_0010); chk("rst_pend", pend, 0);
    step('0, FF, 0, 0);
    step(16'h0008, FF, 0, 0); idle(SL);
    chk("edge_pend3", pend[3], 1); chk("edge_noreq_yet", req, 0);
    step('0, FF, 0, 0);
    chk("edge_req", req, 1); chk("edge_id", id, 3); chk("edge_cause", cause, 32'h8000_0013);
    step('0, FF, 1, 0);
    chk("ack_pend3", pend[3], 0); chk("ack_req", req, 0);
    step('0, FF, 0, 1); step('0, FF, 0, 0);
    chk("ret_idle_req", req, 0);
    step(16'h0220, FF, 0, 0); idle(SL); step('0, FF, 0, 0);
    chk("prio_req", req, 1); chk("prio_id5", id, 5);
    step('0, FF, 1, 0); step('0, FF, 0, 1);
    chk("prio_gap", req, 0);
    step('0, FF, 0, 0);
    chk("prio9_req", req, 1); chk("prio9_id", id, 9); chk("prio9_cause", cause, 32'h8000_0019);
    step('0, FF, 1, 0); step('0, FF, 0, 1);
    step(16'h0020, FF, 0, 0); idle(SL); step('0, FF, 0, 0);
    chk("frz_req5", id, 5);
    step(16'h0002, FF, 0, 0); idle(SL + 1);
    chk("frz_id", id, 5); chk("frz_req", req, 1); chk("frz_pend1", pend[1], 1);
    step('0, FF, 1, 0); step('0, FF, 0, 1); step('0, FF, 0, 0);
    chk("frz_next_id1", id, 1); chk("frz_next_req", req, 1);
    step('0, FF, 1, 0); step('0, FF, 0, 1);
    step(16'h0004, 16'hFFFB, 0, 0); idle(SL + 2, 16'hFFFB);
    chk("mask_pend2", pend[2], 1); chk("mask_noreq", req, 0);
    step('0, FF, 0, 0);
    chk("mask_req", req, 1); chk("mask_id2", id, 2);
    step('0, FF, 1, 0); step('0, FF, 0, 1);
    step(16'h0001, FF, 0, 0); idle(SL);
    chk("lvl_pend0", pend[0], 1);
    step(16'h0001, FF, 0, 0);
    chk("lvl_req", req, 1); chk("lvl_id0", id, 0);
    step(16'h0001, FF, 1, 0);
    chk("lvl_ack_pend0", pend[0], 1);
    step(16'h0001, FF, 0, 1);
    chk("lvl_gap", req, 0);
    step(16'h0001, FF, 0, 0);
    chk("lvl_rereq", req, 1); chk("lvl_rereq_id", id, 0);
    step(16'h0001, FF, 1, 0); step('0, FF, 0, 0); idle(SL);
    chk("lvl_drop_pend0", pend[0], 0);
    step('0, FF, 0, 1); step('0, FF, 0, 0);
    chk("lvl_drop_noreq", req, 0);
    step(16'h0010, FF, 0, 0); idle(SL); step('0, FF, 0, 0);
    chk("sw_req4", id, 4);
    if (SL == 0) step(16'h0010, FF, 1, 0);
    else begin
      step(16'h0010, FF, 0, 0); idle(SL - 1); step('0, FF, 1, 0);
    end
    chk("setwin_pend4", pend[4], 1); chk("setwin_req", req, 0);
    step('0, FF, 0, 1); step('0, FF, 0, 0);
    chk("setwin_rereq", req, 1); chk("setwin_id", id, 4);
    step('0, FF, 1, 0); step('0, FF, 0, 1);
    step('0, FF, 1, 0);
    chk("stray_ack", req, 0);
    step('0, FF, 0, 1);
    chk("stray_ret", req, 0); chk("stray_pend", pend, 0);
    step(16'h0040, FF, 0, 0); idle(SL); step('0, FF, 0, 0);
    chk("stray_after_req", req, 1); chk("stray_after_id", id, 6);
    step('0, FF, 1, 0); step('0, FF, 0, 1);
    step(16'h0100, FF, 0, 0); idle(SL); step('0, FF, 0, 0);
    chk("midrst_req", req, 1);
    step('0, FF, 0, 0, 1);
    step('0, FF, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 3) == 0) ? N'($urandom) : FF;
      step(N'($urandom & $urandom & $urandom), e, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, r);
    end
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
